mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/arb_starve_cnt.sv | 34 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_DATA  = 2'd2
    } arb_grant_t;

    // Wide enough for the largest legal starvation limit (15).
    localparam int unsigned STARVE_CNT_W = 4;

    // Data wins contention unless fetch has waited out its starvation budget.
    function automatic arb_grant_t pick_grant(input logic if_req,
                                              input logic dm_req,
                                              input logic limit_hit);
        arb_grant_t g;
        g = GNT_NONE;
        if (if_req && dm_req) begin
            g = limit_hit ? GNT_FETCH : GNT_DATA;
        end else if (dm_req) begin
            g = GNT_DATA;
        end else if (if_req) begin
            g = GNT_FETCH;
        end
        return g;
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts data grants issued while fetch is waiting; flags when fetch must win.
// Latency: limit_hit reflects grants up to the previous clock edge.
// Backpressure: none; purely observes grant events.
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic data_grant,
    input  logic fetch_grant,
    input  logic if_req,
    output logic limit_hit
);
    import mem_arb_pkg::*;

    localparam int unsigned LIMIT_INT = STARVE_LIMIT;
    localparam logic [STARVE_CNT_W-1:0] LIMIT = LIMIT_INT[STARVE_CNT_W-1:0];

    logic [STARVE_CNT_W-1:0] cnt_q;

    // Clearing dominates: fetch served or not waiting means no starvation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (fetch_grant || !if_req) begin
            cnt_q <= '0;
        end else if (data_grant && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign limit_hit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port bram.
// Latency: request sampled in IDLE -> ACCESS next cycle -> valid the cycle after (3-cycle turn).
// Backpressure: requests are levels held until their valid; losers simply wait in IDLE.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    import mem_arb_pkg::*;

    arb_state_t state_q, state_nxt;
    arb_grant_t grant_q, grant_nxt;
    logic       wr_q, wr_nxt;
    logic       limit_hit;
    logic       data_grant;
    logic       fetch_grant;
    logic       mem_write_st;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .data_grant  (data_grant),
        .fetch_grant (fetch_grant),
        .if_req      (if_req),
        .limit_hit   (limit_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            wr_q    <= wr_nxt;
        end
    end

    // Store/load is captured at grant so a requester that drops its level
    // mid-transaction cannot turn a load into a write or vice versa.
    always_comb begin
        state_nxt   = state_q;
        grant_nxt   = grant_q;
        wr_nxt      = wr_q;
        data_grant  = 1'b0;
        fetch_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_nxt   = pick_grant(if_req, dm_req, limit_hit);
                data_grant  = (grant_nxt == GNT_DATA);
                fetch_grant = (grant_nxt == GNT_FETCH);
                wr_nxt      = data_grant & dm_write;
                if (grant_nxt != GNT_NONE) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                grant_nxt = GNT_NONE;
                wr_nxt    = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = GNT_NONE;
                wr_nxt    = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        mem_addr     = '0;
        mem_write_st = 1'b0;
        mem_wdata    = '0;
        if_valid     = 1'b0;
        if_rdata     = '0;
        dm_valid     = 1'b0;
        dm_rdata     = '0;
        case (state_q)
            ST_ACCESS: begin
                if (grant_q == GNT_DATA) begin
                    mem_addr     = dm_addr;
                    mem_write_st = wr_q;
                    mem_wdata    = dm_wdata;
                end else if (grant_q == GNT_FETCH) begin
                    mem_addr = if_addr;
                end
            end
            ST_RESP: begin
                if (grant_q == GNT_FETCH) begin
                    if_valid = 1'b1;
                    if_rdata = mem_rdata;
                end else if (grant_q == GNT_DATA) begin
                    dm_valid = 1'b1;
                    dm_rdata = wr_q ? 32'd0 : mem_rdata;
                end
            end
            default: begin
                busy = (state_q != ST_IDLE);
            end
        endcase
    end

    // A reset landing mid-store must kill the write strobe before the next edge.
    assign mem_write = mem_write_st & rst;

    a_valid_excl: assert property (@(posedge clk) disable iff (!rst) !(if_valid && dm_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read bram model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] bram [0:255];

    int n_vec;
    int n_err;

    mem_arbiter #(
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_write  (dm_write),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) begin
            bram[mem_addr[9:2]] <= mem_wdata;
        end
        mem_rdata <= bram[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Runs one request from IDLE over a fixed 6-cycle window and checks timing,
    // the bram strobes in ACCESS, the response data and idle-bus quietness.
    task automatic txn(input string tag, input logic fetch, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wd, input logic [31:0] exp_rd);
        int          nbusy, nwr, nmine, nother, when_v, bad_bus;
        logic        mine, other;
        logic [31:0] rd, acc_addr, acc_wd;
        nbusy = 0; nwr = 0; nmine = 0; nother = 0; when_v = -1; bad_bus = 0;
        rd = 32'd0; acc_addr = 32'd0; acc_wd = 32'd0;
        if (fetch) begin
            if_addr = addr;
            if_req  = 1'b1;
        end else begin
            dm_addr  = addr;
            dm_write = wr;
            dm_wdata = wd;
            dm_req   = 1'b1;
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            mine  = fetch ? if_valid : dm_valid;
            other = fetch ? dm_valid : if_valid;
            if (busy) nbusy++;
            if (mem_write) nwr++;
            if (busy && !if_valid && !dm_valid) begin
                acc_addr = mem_addr;
                acc_wd   = mem_wdata;
            end else if (mem_addr != 32'd0 || mem_wdata != 32'd0) begin
                bad_bus++;
            end
            if (mine) begin
                nmine++;
                when_v = k;
                rd     = fetch ? if_rdata : dm_rdata;
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            if (other) nother++;
        end
        chk({tag, ".busy_cycles"}, nbusy, 2);
        chk({tag, ".valid_count"}, nmine, 1);
        chk({tag, ".valid_cycle"}, when_v, 2);
        chk({tag, ".other_valid"}, nother, 0);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".mem_addr"}, acc_addr, addr);
        chk({tag, ".mem_wdata"}, acc_wd, fetch ? 32'd0 : wd);
        chk({tag, ".write_cycles"}, nwr, (!fetch && wr) ? 1 : 0);
        chk({tag, ".idle_bus"}, bad_bus, 0);
    endtask

    initial begin
        logic [7:0] hist;
        int         nv, nb, last, both;

        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) bram[i] = 32'd0;
        bram[32'h10 >> 2] = 32'hDEADBEEF;
        bram[32'h30 >> 2] = 32'hAAAA5555;
        bram[32'h40 >> 2] = 32'h0BADF00D;
        mem_rdata = 32'd0;

        // A fetch is already pending during reset; it must not start early.
        rst      = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h10;
        dm_req   = 1'b0;
        dm_write = 1'b0;
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;

        #12;
        chk("reset.busy", busy, 0);
        chk("reset.if_valid", if_valid, 0);
        chk("reset.dm_valid", dm_valid, 0);
        chk("reset.if_rdata", if_rdata, 0);
        chk("reset.dm_rdata", dm_rdata, 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_write", mem_write, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        txn("fetch", 1'b1, 32'h10, 1'b0, 32'd0, 32'hDEADBEEF);
        txn("store", 1'b0, 32'h20, 1'b1, 32'h1234, 32'd0);
        txn("load", 1'b0, 32'h20, 1'b0, 32'h5555, 32'h1234);

        // Continuous contention: expect D,D,D,F,D,D,D,F at one grant per 3 cycles.
        if_addr  = 32'h10;
        dm_addr  = 32'h20;
        dm_write = 1'b0;
        if_req   = 1'b1;
        dm_req   = 1'b1;
        hist = 8'd0; nv = 0; last = 0; both = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (if_valid && dm_valid) both++;
            if (if_valid || dm_valid) begin
                if (nv < 8) hist[nv] = if_valid;
                nv++;
                last = k;
                if (nv == 8) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        chk("starve.order", {24'd0, hist}, 32'h88);
        chk("starve.grants", nv, 8);
        chk("starve.last_cycle", last, 23);
        chk("starve.both_valid", both, 0);

        // Reset lands mid-store: strobe must drop at once and no response follows.
        dm_addr  = 32'h30;
        dm_write = 1'b1;
        dm_wdata = 32'h5A5A;
        dm_req   = 1'b1;
        @(posedge clk); #1;
        chk("rst_acc.write_before", mem_write, 1);
        chk("rst_acc.addr_before", mem_addr, 32'h30);
        #2 rst = 1'b0;
        #1;
        chk("rst_acc.write_async", mem_write, 0);
        chk("rst_acc.busy_async", busy, 0);
        chk("rst_acc.addr_async", mem_addr, 0);
        dm_req   = 1'b0;
        dm_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        nv = 0; nb = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (if_valid || dm_valid) nv++;
            if (busy) nb++;
        end
        chk("rst_acc.no_valid", nv, 0);
        chk("rst_acc.no_busy", nb, 0);
        chk("rst_acc.bram_kept", bram[32'h30 >> 2], 32'hAAAA5555);
        txn("post_rst_load", 1'b0, 32'h30, 1'b0, 32'd0, 32'hAAAA5555);

        // Alternating single requesters separated by idle gaps.
        txn("alt_fetch0", 1'b1, 32'h40, 1'b0, 32'd0, 32'h0BADF00D);
        txn("alt_store", 1'b0, 32'h44, 1'b1, 32'hCAFE, 32'd0);
        txn("alt_fetch1", 1'b1, 32'h44, 1'b0, 32'd0, 32'hCAFE);
        txn("alt_load", 1'b0, 32'h40, 1'b0, 32'h9999, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
